// File: rtl/centroid_overlay.sv
// Composites colour-centroid crosshairs and the tracking-region outline onto the camera pixel stream.
// Centroids are captured at end_frame and committed at frame start, with a LOST/TRACK/COAST tracker per colour.
module centroid_overlay #(
  parameter int          UPPER_X     = 353,
  parameter int          UPPER_Y     = 272,
  parameter int          LOWER_X     = 459,
  parameter int          LOWER_Y     = 368,
  parameter int          ARM         = 8,
  parameter int          HOLD_FRAMES = 4,
  parameter logic [17:0] GREEN_MARK  = 18'h3F000,
  parameter logic [17:0] BLUE_MARK   = 18'h3FFC0,
  parameter logic [17:0] BOX_COLOR   = 18'h3FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        display,
  input  logic [17:0] pixel_in,
  input  logic        end_frame,
  input  logic [23:0] x_avg_green,
  input  logic [23:0] y_avg_green,
  input  logic [23:0] x_avg_blue,
  input  logic [23:0] y_avg_blue,
  output logic [17:0] pixel_out,
  output logic        display_out,
  output logic [1:0]  green_state,
  output logic [1:0]  blue_state
);

  typedef enum logic [1:0] {ST_LOST = 2'd0, ST_TRACK = 2'd1, ST_COAST = 2'd2} state_t;

  localparam int                 MISS_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [MISS_W-1:0]  MISS_MAX = MISS_W'(HOLD_FRAMES);
  localparam logic signed [11:0] ARM_S = 12'(ARM);
  localparam logic [10:0]        UX = 11'(UPPER_X);
  localparam logic [10:0]        LX = 11'(LOWER_X);
  localparam logic [9:0]         UY = 10'(UPPER_Y);
  localparam logic [9:0]         LY = 10'(LOWER_Y);

  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] m);
    return (m >= MISS_MAX) ? MISS_MAX : m + MISS_W'(1);
  endfunction

  // Signed 12-bit differences keep arms from wrapping around screen edges.
  function automatic logic mark_hit(input logic [10:0] h, input logic [9:0] v,
                                    input logic [10:0] x, input logic [9:0] y);
    logic signed [11:0] dx;
    logic signed [11:0] dy;
    dx = $signed({1'b0, h}) - $signed({1'b0, x});
    dy = $signed({2'b00, v}) - $signed({2'b00, y});
    return ((v == y) && (dx >= -ARM_S) && (dx <= ARM_S)) ||
           ((h == x) && (dy >= -ARM_S) && (dy <= ARM_S));
  endfunction

  logic [23:0]       w_raw_x   [2];
  logic [23:0]       w_raw_y   [2];
  logic              w_cap_vld [2];
  logic              w_eff_pnd [2];
  logic              w_eff_vld [2];
  logic [10:0]       w_eff_x   [2];
  logic [9:0]        w_eff_y   [2];
  logic              w_fs;
  state_t            w_st_nxt  [2];
  logic [MISS_W-1:0] w_miss_nxt[2];
  logic [10:0]       w_ax_nxt  [2];
  logic [9:0]        w_ay_nxt  [2];
  logic              w_hit     [2];
  logic              w_box;

  logic              r_pnd     [2];
  logic              r_pnd_vld [2];
  logic [10:0]       r_pnd_x   [2];
  logic [9:0]        r_pnd_y   [2];
  logic [10:0]       r_act_x   [2];
  logic [9:0]        r_act_y   [2];
  logic [MISS_W-1:0] r_miss    [2];
  state_t            r_state   [2];
  logic [17:0]       r_pix_p1;
  logic              r_disp_p1;

  assign w_raw_x[0] = x_avg_green;
  assign w_raw_y[0] = y_avg_green;
  assign w_raw_x[1] = x_avg_blue;
  assign w_raw_y[1] = y_avg_blue;
  assign w_fs       = (hcount == 11'd0) && (vcount == 10'd0);

  // A capture arriving on the frame-start cycle bypasses the pending registers.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_cap_vld[i] = (w_raw_x[i] != 24'd0) && (w_raw_y[i] != 24'd0) &&
                     (w_raw_x[i][23:11] == 13'd0) && (w_raw_y[i][23:10] == 14'd0);
      w_eff_pnd[i] = end_frame | r_pnd[i];
      w_eff_vld[i] = end_frame ? w_cap_vld[i] : r_pnd_vld[i];
      w_eff_x[i]   = end_frame ? w_raw_x[i][10:0] : r_pnd_x[i];
      w_eff_y[i]   = end_frame ? w_raw_y[i][9:0]  : r_pnd_y[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_st_nxt[i]   = r_state[i];
      w_miss_nxt[i] = r_miss[i];
      w_ax_nxt[i]   = r_act_x[i];
      w_ay_nxt[i]   = r_act_y[i];
      if (w_fs) begin
        if (w_eff_pnd[i] && w_eff_vld[i]) begin
          w_st_nxt[i]   = ST_TRACK;
          w_miss_nxt[i] = '0;
          w_ax_nxt[i]   = w_eff_x[i];
          w_ay_nxt[i]   = w_eff_y[i];
        end else begin
          w_miss_nxt[i] = sat_inc(r_miss[i]);
          case (r_state[i])
            ST_TRACK: w_st_nxt[i] = ST_COAST;
            ST_COAST: w_st_nxt[i] = ((32'(r_miss[i]) + 1) >= HOLD_FRAMES) ? ST_LOST : ST_COAST;
            default:  w_st_nxt[i] = ST_LOST;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_pnd[i]     <= 1'b0;
        r_pnd_vld[i] <= 1'b0;
        r_pnd_x[i]   <= '0;
        r_pnd_y[i]   <= '0;
        r_act_x[i]   <= '0;
        r_act_y[i]   <= '0;
        r_miss[i]    <= '0;
        r_state[i]   <= ST_LOST;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_fs) begin
          r_pnd[i] <= 1'b0;
        end else if (end_frame) begin
          r_pnd[i]     <= 1'b1;
          r_pnd_vld[i] <= w_cap_vld[i];
          r_pnd_x[i]   <= w_raw_x[i][10:0];
          r_pnd_y[i]   <= w_raw_y[i][9:0];
        end
        r_state[i] <= w_st_nxt[i];
        r_miss[i]  <= w_miss_nxt[i];
        r_act_x[i] <= w_ax_nxt[i];
        r_act_y[i] <= w_ay_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_hit[i] = (r_state[i] != ST_LOST) && mark_hit(hcount, vcount, r_act_x[i], r_act_y[i]);
    end
    w_box = (((hcount == UX) || (hcount == LX)) && (vcount >= UY) && (vcount <= LY)) ||
            (((vcount == UY) || (vcount == LY)) && (hcount >= UX) && (hcount <= LX));
  end

  // Stage p1: registered composite output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_p1  <= '0;
      r_disp_p1 <= 1'b0;
    end else begin
      r_disp_p1 <= display;
      if (!display)     r_pix_p1 <= '0;
      else if (w_hit[0]) r_pix_p1 <= GREEN_MARK;
      else if (w_hit[1]) r_pix_p1 <= BLUE_MARK;
      else if (w_box)    r_pix_p1 <= BOX_COLOR;
      else               r_pix_p1 <= pixel_in;
    end
  end

  assign pixel_out   = r_pix_p1;
  assign display_out = r_disp_p1;
  assign green_state = r_state[0];
  assign blue_state  = r_state[1];

endmodule

// File: tb/tb_centroid_overlay.sv
// Directed bench for centroid_overlay: pixel expectations queued at drive time and checked one cycle later.
module tb_centroid_overlay;
  localparam logic [17:0] GM = 18'h3F000;
  localparam logic [17:0] BM = 18'h3FFC0;
  localparam logic [17:0] BX = 18'h3FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        display = 1'b0;
  logic [17:0] pixel_in = '0;
  logic        end_frame = 1'b0;
  logic [23:0] xg = '0, yg = '0, xb = '0, yb = '0;
  logic [17:0] pixel_out;
  logic        display_out;
  logic [1:0]  green_state, blue_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [17:0] exp;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  centroid_overlay dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .display(display),
    .pixel_in(pixel_in), .end_frame(end_frame),
    .x_avg_green(xg), .y_avg_green(yg), .x_avg_blue(xb), .y_avg_blue(yb),
    .pixel_out(pixel_out), .display_out(display_out),
    .green_state(green_state), .blue_state(blue_state)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pin_of(input logic [10:0] h, input logic [9:0] v);
    return {h[8:0], v[8:0]};
  endfunction

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives one pixel, queues its expected output, and returns at the following negedge.
  task automatic step(input logic [10:0] h, input logic [9:0] v, input logic disp,
                      input logic ef, input logic chk, input logic [17:0] exp, input string tag);
    exp_t e;
    hcount    = h;
    vcount    = v;
    display   = disp;
    pixel_in  = pin_of(h, v);
    end_frame = ef;
    if (chk) begin
      e.exp = exp;
      e.tag = tag;
      sb_q.push_back(e);
    end
    @(negedge clk);
    end_frame = 1'b0;
  endtask

  task automatic pix(input logic [10:0] h, input logic [9:0] v, input logic [17:0] exp, input string tag);
    step(h, v, 1'b1, 1'b0, 1'b1, exp, tag);
  endtask

  task automatic frame_start(input logic ef);
    step(11'd0, 10'd0, 1'b1, ef, 1'b0, 18'd0, "fs");
  endtask

  task automatic capture(input logic [10:0] h, input logic [9:0] v);
    step(h, v, 1'b1, 1'b1, 1'b0, 18'd0, "cap");
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.tag, pixel_out, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_pix", pixel_out, 18'd0);
    check("rst_disp", 18'(display_out), 18'd0);
    check("rst_gst", 18'(green_state), 18'd0);
    check("rst_bst", 18'(blue_state), 18'd0);
    reset = 1'b0;
    @(negedge clk);

    // Green only
    xg = 24'd400; yg = 24'd320; xb = 24'd0; yb = 24'd0;
    capture(11'd100, 10'd100);
    frame_start(1'b0);
    check("g_track", 18'(green_state), 18'd1);
    check("b_lost", 18'(blue_state), 18'd0);
    pix(11'd392, 10'd320, GM, "g_hl");
    pix(11'd408, 10'd320, GM, "g_hr");
    pix(11'd400, 10'd312, GM, "g_vt");
    pix(11'd400, 10'd328, GM, "g_vb");
    pix(11'd409, 10'd320, pin_of(11'd409, 10'd320), "g_hpast");
    pix(11'd391, 10'd320, pin_of(11'd391, 10'd320), "g_hbefore");
    pix(11'd400, 10'd329, pin_of(11'd400, 10'd329), "g_vpast");
    check("disp_out1", 18'(display_out), 18'd1);

    // Green and blue overlap
    xb = 24'd404; yb = 24'd320;
    capture(11'd100, 10'd100);
    frame_start(1'b0);
    check("both_gst", 18'(green_state), 18'd1);
    check("both_bst", 18'(blue_state), 18'd1);
    pix(11'd404, 10'd320, GM, "overlap");
    pix(11'd404, 10'd321, BM, "b_varm");
    pix(11'd412, 10'd320, BM, "b_harm");

    // Coasting without captures
    frame_start(1'b0);
    check("coast1", 18'(green_state), 18'd2);
    pix(11'd400, 10'd320, GM, "coast1_pix");
    frame_start(1'b0);
    check("coast2", 18'(green_state), 18'd2);
    frame_start(1'b0);
    check("coast3", 18'(green_state), 18'd2);
    pix(11'd400, 10'd320, GM, "coast3_pix");
    frame_start(1'b0);
    check("lost_g", 18'(green_state), 18'd0);
    check("lost_b", 18'(blue_state), 18'd0);
    pix(11'd400, 10'd320, pin_of(11'd400, 10'd320), "lost_pix");
    pix(11'd404, 10'd321, pin_of(11'd404, 10'd321), "lost_bpix");

    // Capture coinciding with frame start
    xg = 24'd0; yg = 24'd0; xb = 24'd380; yb = 24'd300;
    frame_start(1'b1);
    check("byp_bst", 18'(blue_state), 18'd1);
    check("byp_gst", 18'(green_state), 18'd0);
    pix(11'd380, 10'd300, BM, "byp_c");
    pix(11'd372, 10'd300, BM, "byp_l");
    pix(11'd371, 10'd300, pin_of(11'd371, 10'd300), "byp_out");
    pix(11'd380, 10'd292, BM, "byp_t");

    // Mid-frame capture takes effect only at the next frame
    xg = 24'd400; yg = 24'd320;
    capture(11'd50, 10'd50);
    frame_start(1'b0);
    check("mid_gst", 18'(green_state), 18'd1);
    xg = 24'd420; yg = 24'd340;
    capture(11'd100, 10'd200);
    pix(11'd400, 10'd320, GM, "mid_old");
    pix(11'd420, 10'd340, pin_of(11'd420, 10'd340), "mid_new_early");
    frame_start(1'b0);
    pix(11'd420, 10'd340, GM, "next_new");
    pix(11'd400, 10'd320, pin_of(11'd400, 10'd320), "next_old");

    // Box and blanking
    pix(11'd353, 10'd300, BX, "box_l");
    pix(11'd354, 10'd300, pin_of(11'd354, 10'd300), "box_in");
    pix(11'd459, 10'd368, BX, "box_corner");
    step(11'd353, 10'd300, 1'b0, 1'b0, 1'b1, 18'd0, "blank");
    check("disp_out0", 18'(display_out), 18'd0);

    // Asynchronous reset between clock edges
    pix(11'd420, 10'd340, GM, "pre_rst");
    #2;
    reset = 1'b1;
    #1;
    check("arst_pix", pixel_out, 18'd0);
    check("arst_gst", 18'(green_state), 18'd0);
    check("arst_bst", 18'(blue_state), 18'd0);
    @(negedge clk);
    reset = 1'b0;
    frame_start(1'b0);
    pix(11'd420, 10'd340, pin_of(11'd420, 10'd340), "post_rst_g");
    pix(11'd380, 10'd300, pin_of(11'd380, 10'd300), "post_rst_b");
    step(11'd5, 10'd5, 1'b0, 1'b0, 1'b0, 18'd0, "idle");
    step(11'd6, 10'd5, 1'b0, 1'b0, 1'b0, 18'd0, "idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
